// File: rtl/edge_result_writer_if.sv
// Memory write port used by the Sobel result writer.
// The writer raises start_write for one cycle with addr_w/data_w already valid and
// holds them until the memory pulses write_done; it never starts a write while busy is high.
interface edge_result_writer_if #(
    parameter int ADDR_W = 8
);
    logic              busy;
    logic              write_done;
    logic              start_write;
    logic [ADDR_W-1:0] addr_w;
    logic [7:0]        data_w;

    modport master (
        input  busy,
        input  write_done,
        output start_write,
        output addr_w,
        output data_w
    );

    modport slave (
        output busy,
        output write_done,
        input  start_write,
        input  addr_w,
        input  data_w
    );
endinterface

// File: rtl/edge_result_writer.sv
// Output stage of the Sobel pipeline. Walks a width x length frame in raster order,
// writes 0x00 on the 1-pixel border ring and the (optionally thresholded) gradient
// magnitude on interior pixels, taking interior values from a small input FIFO.
//
// Stream handshake (g side): a value transfers on every rising edge where
// g_valid && g_ready; g_ready is high whenever the FIFO has room outside IDLE.
module edge_result_writer #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [11:0]         width,
    input  logic [11:0]         length,
    input  logic [ADDR_W-1:0]   initial_addr_w,
    input  logic [7:0]          threshold,
    input  logic                binarize,
    input  logic [7:0]          g,
    input  logic                g_valid,
    output logic                g_ready,
    edge_result_writer_if.master mem,
    output logic                active,
    output logic                frame_done,
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int         PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [1:0]        state;
    logic [11:0]       wid_r;
    logic [11:0]       len_r;
    logic [7:0]        thr_r;
    logic              bin_r;
    logic [11:0]       row;
    logic [11:0]       col;
    logic [ADDR_W-1:0] addr;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              border;
    logic              last_pix;
    logic              issue_now;
    logic              push;
    logic              pop;
    logic [7:0]        head;
    logic [7:0]        pix_data;

    // Pixel classification, issue condition and data selection for the current pixel.
    always_comb begin
        border    = (row == 12'd0) || (row == len_r - 12'd1) ||
                    (col == 12'd0) || (col == wid_r - 12'd1);
        last_pix  = (row == len_r - 12'd1) && (col == wid_r - 12'd1);
        issue_now = (state == S_ISSUE) && (border || (count != '0)) && !mem.busy;
        g_ready   = (count != FIFO_FULL) && (state != S_IDLE);
        push      = g_valid && g_ready;
        pop       = issue_now && !border;
        head      = fifo_mem[rd_ptr];
        if (border) begin
            pix_data = 8'h00;
        end else if (bin_r) begin
            pix_data = (head >= thr_r) ? 8'hFF : 8'h00;
        end else begin
            pix_data = head;
        end
        active    = (state == S_ISSUE) || (state == S_WAIT);
        state_dbg = state;
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= g;
        end
    end

    // FIFO pointers and occupancy; DONE discards anything left over.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == S_DONE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame walker: capture configuration, issue one write per pixel, advance raster position.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= S_IDLE;
            wid_r           <= '0;
            len_r           <= '0;
            thr_r           <= '0;
            bin_r           <= 1'b0;
            row             <= '0;
            col             <= '0;
            addr            <= '0;
            mem.start_write <= 1'b0;
            mem.addr_w      <= '0;
            mem.data_w      <= '0;
            frame_done      <= 1'b0;
        end else begin
            mem.start_write <= 1'b0;
            frame_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wid_r <= width;
                        len_r <= length;
                        thr_r <= threshold;
                        bin_r <= binarize;
                        addr  <= initial_addr_w;
                        row   <= '0;
                        col   <= '0;
                        if ((width == 12'd0) || (length == 12'd0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_now) begin
                        mem.start_write <= 1'b1;
                        mem.addr_w      <= addr;
                        mem.data_w      <= pix_data;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.write_done) begin
                        addr <= addr + ADDR_W'(1);
                        if (last_pix) begin
                            state <= S_DONE;
                        end else begin
                            if (col == wid_r - 12'd1) begin
                                col <= '0;
                                row <= row + 12'd1;
                            end else begin
                                col <= col + 12'd1;
                            end
                            state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_result_writer.sv
// Bench for edge_result_writer: memory responder, g stream feeder, frame-level
// reference model and a write scoreboard.
`timescale 1ns/1ps
module tb_edge_result_writer;
    localparam int ADDR_W = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [11:0]       width = '0;
    logic [11:0]       length = '0;
    logic [ADDR_W-1:0] initial_addr_w = '0;
    logic [7:0]        threshold = '0;
    logic              binarize = 1'b0;
    logic [7:0]        g = '0;
    logic              g_valid = 1'b0;
    logic              g_ready;
    logic              active;
    logic              frame_done;
    logic [1:0]        state_dbg;

    edge_result_writer_if #(.ADDR_W(ADDR_W)) mem_if ();

    edge_result_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .width          (width),
        .length         (length),
        .initial_addr_w (initial_addr_w),
        .threshold      (threshold),
        .binarize       (binarize),
        .g              (g),
        .g_valid        (g_valid),
        .g_ready        (g_ready),
        .mem            (mem_if),
        .active         (active),
        .frame_done     (frame_done),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [7:0]  g_ref[$];
    logic [7:0]  g_src[$];
    int fd_cnt = 0, busy_err = 0, stab_err = 0, sw_cnt = 0, pushed = 0;
    int wd_delay = 0;
    bit feed_en = 0, gap_rand = 0, busy_rand = 0, fire_s = 0;
    logic busy_force = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder / monitor (samples on falling edge) ----------------
    bit pend = 0;
    int wd_cnt = 0;
    logic [15:0] cur = '0;
    logic last_busy = 1'b0;
    always @(negedge clk) begin
        fire_s = g_valid && g_ready && n_rst;
        if (!n_rst) begin
            pend = 0;
            mem_if.write_done = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            mem_if.write_done = 1'b0;
            if (mem_if.start_write) begin
                sw_cnt++;
                if (last_busy) busy_err++;
                cur = {mem_if.addr_w, mem_if.data_w};
                got_q.push_back(cur);
                pend = 1;
                wd_cnt = wd_delay;
            end
            if (pend) begin
                if ({mem_if.addr_w, mem_if.data_w} !== cur) stab_err++;
                if (wd_cnt == 0) begin
                    mem_if.write_done = 1'b1;
                    pend = 0;
                end else begin
                    wd_cnt--;
                end
            end
        end
        last_busy = mem_if.busy;
    end

    // ---------------- g stream driver ----------------
    always @(posedge clk) begin
        #1;
        if (fire_s && g_src.size() > 0) begin
            void'(g_src.pop_front());
            pushed++;
        end
        if (feed_en && g_src.size() > 0 && (!gap_rand || $urandom_range(0, 3) != 0)) begin
            g_valid = 1'b1;
            g = g_src[0];
        end else begin
            g_valid = 1'b0;
            g = 8'($urandom);
        end
    end

    // ---------------- busy driver ----------------
    always @(posedge clk) begin
        #2;
        mem_if.busy = busy_rand ? ($urandom_range(0, 3) == 0) : busy_force;
    end

    // ---------------- reference model: whole frame as an address/data list ----------------
    function automatic void build_exp(int w, int l, logic [7:0] init, logic [7:0] thr, bit bin);
        int k = 0;
        logic [7:0] a, d, v;
        exp_q.delete();
        for (int r = 0; r < l; r++) begin
            for (int c = 0; c < w; c++) begin
                a = init + 8'(r * w + c);
                if (r == 0 || r == l - 1 || c == 0 || c == w - 1) begin
                    d = 8'h00;
                end else begin
                    v = g_ref[k];
                    k++;
                    d = bin ? ((v >= thr) ? 8'hFF : 8'h00) : v;
                end
                exp_q.push_back({a, d});
            end
        end
    endfunction

    task automatic frame_begin(int w, int l, logic [7:0] init, logic [7:0] thr, bit bin, bit preset);
        int n = (w > 2 ? w - 2 : 0) * (l > 2 ? l - 2 : 0);
        if (!preset) begin
            g_ref.delete();
            for (int i = 0; i < n; i++) g_ref.push_back(8'($urandom));
        end
        g_src = g_ref;
        build_exp(w, l, init, thr, bin);
        got_q.delete();
        fd_cnt = 0; busy_err = 0; stab_err = 0; pushed = 0; sw_cnt = 0;
        busy_force = 1'b0;
        @(posedge clk); #1;
        width = 12'(w); length = 12'(l); initial_addr_w = init;
        threshold = thr; binarize = bin; start = 1'b1; feed_en = 1;
        @(posedge clk); #1;
        start = 1'b0;
        width = 12'($urandom); length = 12'($urandom);
        initial_addr_w = 8'($urandom); threshold = 8'($urandom); binarize = 1'($urandom);
    endtask

    task automatic frame_end(string name, int exp_writes, int exp_pops);
        int cyc = 0;
        while (fd_cnt == 0 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_timeout", name), 32'(cyc < 6000), 32'd1);
        repeat (5) @(negedge clk);
        check($sformatf("%s_frame_done_cnt", name), fd_cnt, 1);
        check($sformatf("%s_writes", name), got_q.size(), exp_writes);
        check($sformatf("%s_model_len", name), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_wr%0d", name, i), got_q[i], exp_q[i]);
        check($sformatf("%s_g_consumed", name), pushed, exp_pops);
        check($sformatf("%s_g_left", name), g_src.size(), 0);
        check($sformatf("%s_write_while_busy", name), busy_err, 0);
        check($sformatf("%s_hold_unstable", name), stab_err, 0);
        check($sformatf("%s_active_after", name), active, 0);
        feed_en = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         w;
        int         l;
        logic [7:0] init;
        logic [7:0] thr;
        bit         bin;
        int         wdd;
        bit         noisy;
        int         exp_writes;
        int         exp_pops;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc;
        int bad;
        int w, l;
        logic [7:0] hold_a, hold_d;

        tbl[0] = '{5, 5, 8'h00, 8'd128, 1'b1, 1, 1'b1, 25, 9};
        tbl[1] = '{3, 3, 8'hFE, 8'd0,   1'b0, 0, 1'b0,  9, 1};
        tbl[2] = '{2, 5, 8'h40, 8'd50,  1'b0, 2, 1'b1, 10, 0};
        tbl[3] = '{1, 1, 8'h80, 8'd0,   1'b1, 0, 1'b0,  1, 0};
        tbl[4] = '{7, 3, 8'h20, 8'd77,  1'b0, 1, 1'b1, 21, 5};
        tbl[5] = '{3, 8, 8'hF0, 8'd200, 1'b1, 3, 1'b1, 24, 6};
        tbl[6] = '{0, 5, 8'h11, 8'd9,   1'b0, 0, 1'b0,  0, 0};
        tbl[7] = '{4, 0, 8'h22, 8'd9,   1'b1, 0, 1'b0,  0, 0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start_write", mem_if.start_write, 0);
        check("rst_addr_w", mem_if.addr_w, 0);
        check("rst_data_w", mem_if.data_w, 0);
        check("rst_active", active, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_g_ready", g_ready, 0);
        check("rst_state", state_dbg, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // 4x4 binarized with fixed gradients
        wd_delay = 0; busy_rand = 0; gap_rand = 0;
        g_ref = '{8'd10, 8'd200, 8'd50, 8'd255};
        frame_begin(4, 4, 8'h10, 8'd100, 1'b1, 1'b1);
        frame_end("bin4x4", 16, 4);
        check("bin4x4_0x15", got_q[5], 16'h1500);
        check("bin4x4_0x16", got_q[6], 16'h16FF);
        check("bin4x4_0x19", got_q[9], 16'h1900);
        check("bin4x4_0x1A", got_q[10], 16'h1AFF);
        check("bin4x4_last", got_q[15], 16'h1F00);

        // same frame, raw magnitudes
        g_ref = '{8'd10, 8'd200, 8'd50, 8'd255};
        frame_begin(4, 4, 8'h10, 8'd100, 1'b0, 1'b1);
        frame_end("raw4x4", 16, 4);
        check("raw4x4_0x15", got_q[5], 16'h150A);
        check("raw4x4_0x16", got_q[6], 16'h16C8);
        check("raw4x4_0x19", got_q[9], 16'h1932);
        check("raw4x4_0x1A", got_q[10], 16'h1AFF);

        // busy held high around the 5th pixel
        wd_delay = 2;
        frame_begin(4, 4, 8'h10, 8'd100, 1'b0, 1'b0);
        cyc = 0;
        while (got_q.size() < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_reach_4th", got_q.size(), 4);
        @(posedge clk); #1;
        busy_force = 1'b1;
        hold_a = mem_if.addr_w;
        hold_d = mem_if.data_w;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_if.start_write || mem_if.addr_w !== hold_a || mem_if.data_w !== hold_d) bad++;
        end
        check("busy_no_issue_hold", bad, 0);
        @(posedge clk); #1;
        busy_force = 1'b0;
        @(negedge clk);
        check("busy_fall_cycle_sw", mem_if.start_write, 0);
        @(negedge clk);
        check("busy_after_fall_sw", mem_if.start_write, 1);
        check("busy_after_fall_addr", mem_if.addr_w, 8'h14);
        frame_end("busy4x4", 16, 4);

        // 6x6, slow memory, g_valid held: FIFO fills, then backpressure
        wd_delay = 8;
        frame_begin(6, 6, 8'h30, 8'd90, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        check("fifo_pushes_before_full", pushed, 4);
        check("fifo_g_ready_full", g_ready, 0);
        check("fifo_active_mid", active, 1);
        @(posedge clk); #1;
        width = 12'd2; length = 12'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        frame_end("fifo6x6", 36, 16);

        // empty frame: no writes, frame_done two cycles after start
        wd_delay = 0;
        sw_cnt = 0; fd_cnt = 0;
        @(posedge clk); #1;
        width = 12'd0; length = 12'd5; start = 1'b1;
        @(negedge clk);
        check("w0_fd_c0", frame_done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("w0_fd_c1", frame_done, 0);
        check("w0_active_c1", active, 0);
        @(negedge clk);
        check("w0_fd_c2", frame_done, 1);
        repeat (3) @(negedge clk);
        check("w0_no_write", sw_cnt, 0);
        check("w0_fd_cnt", fd_cnt, 1);

        // reset in the middle of a frame, then a fresh frame with address wrap
        wd_delay = 3;
        frame_begin(3, 3, 8'hFE, 8'd0, 1'b0, 1'b0);
        cyc = 0;
        while (got_q.size() < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk); #1;
        n_rst = 1'b0;
        feed_en = 0;
        @(negedge clk);
        check("mrst_start_write", mem_if.start_write, 0);
        check("mrst_addr_w", mem_if.addr_w, 0);
        check("mrst_data_w", mem_if.data_w, 0);
        check("mrst_active", active, 0);
        check("mrst_frame_done", frame_done, 0);
        check("mrst_g_ready", g_ready, 0);
        g_src.delete();
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (6) @(negedge clk);
        check("mrst_no_frame_done", fd_cnt, 0);
        frame_begin(3, 3, 8'hFE, 8'd0, 1'b0, 1'b0);
        frame_end("wrap3x3", 9, 1);
        check("wrap_addr1", got_q[1][15:8], 8'hFF);
        check("wrap_addr2", got_q[2][15:8], 8'h00);
        check("wrap_addr8", got_q[8][15:8], 8'h06);

        // table-driven frames
        for (int i = 0; i < 8; i++) begin
            wd_delay = tbl[i].wdd;
            busy_rand = tbl[i].noisy;
            gap_rand = tbl[i].noisy;
            frame_begin(tbl[i].w, tbl[i].l, tbl[i].init, tbl[i].thr, tbl[i].bin, 1'b0);
            frame_end($sformatf("tbl%0d", i), tbl[i].exp_writes, tbl[i].exp_pops);
        end

        // random frames
        for (int i = 0; i < 12; i++) begin
            w = $urandom_range(0, 7);
            l = $urandom_range(0, 7);
            wd_delay = $urandom_range(0, 3);
            busy_rand = 1;
            gap_rand = 1;
            frame_begin(w, l, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            frame_end($sformatf("rnd%0d_%0dx%0d", i, w, l), w * l,
                      (w > 2 ? w - 2 : 0) * (l > 2 ? l - 2 : 0));
        end
        busy_rand = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
